lane_demux_rr: RTL and testbench

//   Single-clock receive end of the 4-lane byte serialiser (MuxL1/MuxL2 path).

---
 rtl/lane_demux_rr_if.sv | 33 +++
 rtl/lane_demux_rr.sv | 86 ++++++++
 tb/tb_lane_demux_rr.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lane_demux_rr_if.sv
// lane_demux_rr_if: byte-stream input and frame-output handshake bundle for
// the lane demultiplexer.
//   data_in, valid_in, sync : slot byte, its valid, slot-0 realign marker
//   out_ready               : consumer accepts the presented frame
//   data_out, lane_valid    : presented frame word and per-lane valids
//   out_valid               : a frame is presented
//   overflow, drop_count    : sticky drop flag and saturating drop counter
// master drives the byte stream and out_ready; slave is the demux side.
interface lane_demux_rr_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    sync;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        lane_valid;
  logic                    out_valid;
  logic                    overflow;
  logic [CNT_W-1:0]        drop_count;

  modport master (
    output data_in, valid_in, sync, out_ready,
    input  data_out, lane_valid, out_valid, overflow, drop_count
  );

  modport slave (
    input  data_in, valid_in, sync, out_ready,
    output data_out, lane_valid, out_valid, overflow, drop_count
  );
endinterface

// File: rtl/lane_demux_rr.sv
// lane_demux_rr: receive end of the 4-lane byte serialiser. A time-division
// byte stream (one slot per cycle, slot k = lane k) is gathered back into a
// parallel frame word with per-lane valids and presented on a valid/ready
// handshake. Frames that complete while the output is blocked are dropped
// and counted.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : lane_demux_rr_if slave (byte stream in, frame handshake out)
module lane_demux_rr #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           reset,
  lane_demux_rr_if.slave bus
);
  localparam int          SW  = $clog2(LANES);
  localparam int unsigned LM1 = LANES - 1;

  logic [SW-1:0]                 slot_cnt;
  logic [SW-1:0]                 cur_slot;
  logic                          last;
  logic                          load_ok;
  // Only lanes 0..LANES-2 are buffered; the last lane is taken straight
  // from the bus in the completing cycle.
  logic [LANES-2:0]              coll_v;
  logic [LANES-2:0][DATA_W-1:0]  coll_d;
  logic [LANES-1:0]              frame_v;
  logic [LANES*DATA_W-1:0]       frame_d;

  always_comb begin
    cur_slot = bus.sync ? '0 : slot_cnt;
    last     = (cur_slot == SW'(LM1));
    load_ok  = !bus.out_valid || bus.out_ready;
    frame_v  = {bus.valid_in, coll_v};
    frame_d  = {(bus.valid_in ? bus.data_in : {DATA_W{1'b0}}), coll_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt       <= '0;
      coll_v         <= '0;
      coll_d         <= '0;
      bus.data_out   <= '0;
      bus.lane_valid <= '0;
      bus.out_valid  <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (last) begin
        coll_v <= '0;
        // An all-invalid frame is discarded without touching the output.
        if (|frame_v) begin
          if (load_ok) begin
            bus.data_out   <= frame_d;
            bus.lane_valid <= frame_v;
            bus.out_valid  <= 1'b1;
          end else begin
            bus.overflow <= 1'b1;
            if (bus.drop_count != '1) begin
              bus.drop_count <= bus.drop_count + CNT_W'(1);
            end
          end
        end
      end else begin
        for (int unsigned i = 0; i < LM1; i++) begin
          if (cur_slot == SW'(i)) begin
            coll_v[i] <= bus.valid_in;
            coll_d[i] <= bus.valid_in ? bus.data_in : '0;
          end else if (bus.sync && slot_cnt != '0 && i != 0) begin
            // Realign: the partial frame collected so far is abandoned.
            coll_v[i] <= 1'b0;
          end
        end
      end

      slot_cnt <= cur_slot + SW'(1);
    end
  end
endmodule

// File: tb/tb_lane_demux_rr.sv
module tb_lane_demux_rr;
  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 8;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  lane_demux_rr_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  lane_demux_rr #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the frame being assembled is an array indexed by lane,
  // the held output is a single record, drops are a plain integer clamped
  // to the counter's maximum.
  int                       m_slot;
  int                       m_byte  [LANES];
  bit                       m_have  [LANES];
  bit                       exp_ov;
  bit                       exp_of;
  int                       exp_drops;
  logic [LANES*DATA_W-1:0]  exp_d;
  logic [LANES-1:0]         exp_lv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_slot    = 0;
      exp_ov    = 0;
      exp_of    = 0;
      exp_drops = 0;
      exp_d     = '0;
      exp_lv    = '0;
      for (int k = 0; k < LANES; k++) begin
        m_byte[k] = 0;
        m_have[k] = 0;
      end
    end else begin
      int  s;
      bit  any;
      bit  accepted;
      s = bus.sync ? 0 : m_slot;
      if (s == 0) begin
        // Start of a frame (natural or realigned): nothing earlier survives.
        for (int k = 0; k < LANES; k++) m_have[k] = 0;
      end
      m_have[s] = bus.valid_in;
      m_byte[s] = bus.valid_in ? int'(bus.data_in) : 0;
      m_slot    = (s + 1) % LANES;
      accepted  = exp_ov && bus.out_ready;
      if (accepted) exp_ov = 0;
      if (s == LANES - 1) begin
        any = 0;
        for (int k = 0; k < LANES; k++) any |= m_have[k];
        if (any) begin
          if (!exp_ov) begin
            exp_ov = 1;
            for (int k = 0; k < LANES; k++) begin
              exp_d[k*DATA_W +: DATA_W] = DATA_W'(m_byte[k]);
              exp_lv[k]                 = m_have[k];
            end
          end else begin
            exp_of    = 1;
            exp_drops = (exp_drops + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : exp_drops + 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("m_out_valid", 64'(bus.out_valid), 64'(exp_ov));
      check("m_overflow", 64'(bus.overflow), 64'(exp_of));
      check("m_drop_count", 64'(bus.drop_count), 64'(exp_drops));
      if (exp_ov) begin
        check("m_data_out", 64'(bus.data_out), 64'(exp_d));
        check("m_lane_valid", 64'(bus.lane_valid), 64'(exp_lv));
      end
    end
  end

  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic r);
    bus.sync      = s;
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.sync      = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_drop_count", 64'(bus.drop_count), 64'd0);
    reset = 1'b0;

    // Full frame, all lanes valid.
    step(1, 1, 8'hA0, 1);
    step(0, 1, 8'hA1, 1);
    step(0, 1, 8'hA2, 1);
    step(0, 1, 8'hA3, 1);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_data_out", 64'(bus.data_out), 64'hA3A2A1A0);
    check("t1_lane_valid", 64'(bus.lane_valid), 64'hF);
    step(0, 0, 8'h00, 1);
    check("t1_one_cycle", 64'(bus.out_valid), 64'd0);

    // Lane 2 invalid: its byte is zeroed.
    step(1, 1, 8'hA0, 1);
    step(0, 1, 8'hA1, 1);
    step(0, 0, 8'hA2, 1);
    step(0, 1, 8'hA3, 1);
    check("t2_data_out", 64'(bus.data_out), 64'hA300A1A0);
    check("t2_lane_valid", 64'(bus.lane_valid), 64'hB);
    step(0, 0, 8'h00, 1);

    // Realign mid-frame: the C bytes are lost silently.
    step(1, 1, 8'hC0, 1);
    step(0, 1, 8'hC1, 1);
    step(1, 1, 8'hB0, 1);
    step(0, 1, 8'hB1, 1);
    step(0, 1, 8'hB2, 1);
    check("t4_no_early", 64'(bus.out_valid), 64'd0);
    step(0, 1, 8'hB3, 1);
    check("t4_data_out", 64'(bus.data_out), 64'hB3B2B1B0);
    check("t4_lane_valid", 64'(bus.lane_valid), 64'hF);
    check("t4_drop_count", 64'(bus.drop_count), 64'd0);
    step(0, 0, 8'h00, 1);

    // Empty frame is not presented and not counted.
    step(1, 0, 8'h10, 1);
    step(0, 0, 8'h11, 1);
    step(0, 0, 8'h12, 1);
    step(0, 0, 8'h13, 1);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_drop_count", 64'(bus.drop_count), 64'd0);

    // Blocked output: second frame dropped, first held.
    step(1, 1, 8'hF0, 0);
    step(0, 1, 8'hF1, 0);
    step(0, 1, 8'hF2, 0);
    step(0, 1, 8'hF3, 0);
    step(0, 1, 8'hE0, 0);
    step(0, 1, 8'hE1, 0);
    step(0, 1, 8'hE2, 0);
    step(0, 1, 8'hE3, 0);
    check("t3_held_valid", 64'(bus.out_valid), 64'd1);
    check("t3_held_data", 64'(bus.data_out), 64'hF3F2F1F0);
    check("t3_overflow", 64'(bus.overflow), 64'd1);
    check("t3_drop_count", 64'(bus.drop_count), 64'd1);
    step(0, 0, 8'h00, 1);
    check("t3_accepted", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-frame while a frame is presented.
    step(1, 1, 8'h11, 1);
    step(0, 1, 8'h12, 1);
    step(0, 1, 8'h13, 1);
    step(0, 1, 8'h14, 1);
    step(1, 1, 8'h55, 0);
    step(0, 1, 8'h66, 0);
    #2 reset = 1'b1;
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_data_out", 64'(bus.data_out), 64'd0);
    check("t6_lane_valid", 64'(bus.lane_valid), 64'd0);
    check("t6_overflow", 64'(bus.overflow), 64'd0);
    check("t6_drop_count", 64'(bus.drop_count), 64'd0);
    bus.sync     = 1'b0;
    bus.valid_in = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 8'hD0, 1);
    step(0, 1, 8'hD1, 1);
    step(0, 1, 8'hD2, 1);
    step(0, 1, 8'hD3, 1);
    check("t6_after_data", 64'(bus.data_out), 64'hD3D2D1D0);
    check("t6_after_lv", 64'(bus.lane_valid), 64'hF);
    step(0, 0, 8'h00, 1);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
           8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Long blocked stretch drives the drop counter into saturation.
    for (int n = 0; n < 1100; n++) begin
      step(0, 1, 8'($urandom), 0);
    end
    check("sat_drop_count", 64'(bus.drop_count), 64'd255);
    check("sat_overflow", 64'(bus.overflow), 64'd1);
    for (int n = 0; n < 8; n++) begin
      step(0, 0, 8'h00, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
